// File: rtl/ksa_mw_add_sched_if.sv
// Request/response bus between the client units and ksa_mw_add_sched.
// Signal names keep the direction suffix as seen from the scheduler.
interface ksa_mw_add_sched_if #(
    parameter int unsigned N = 128
);
    logic [1:0]     req_valid_i;
    logic [1:0]     req_ready_o;
    logic [2*N-1:0] req_a_i;
    logic [2*N-1:0] req_b_i;
    logic [1:0]     req_cin_i;
    logic           rsp_valid_o;
    logic           rsp_ready_i;
    logic           rsp_id_o;
    logic [N-1:0]   rsp_sum_o;
    logic           rsp_cout_o;

    // Client side: issues requests, consumes responses.
    modport master (
        output req_valid_i, req_a_i, req_b_i, req_cin_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_sum_o, rsp_cout_o
    );

    // Scheduler side.
    modport slave (
        input  req_valid_i, req_a_i, req_b_i, req_cin_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_id_o, rsp_sum_o, rsp_cout_o
    );
endinterface

// File: rtl/ksa_mw_add_sched.sv
// Two-requester scheduler for multi-word additions over one shared 32-bit
// P/G carry network. One 32-bit word is processed per cycle; the word carry-in
// is injected around the network using the propagate prefix Q.
module ksa_mw_add_sched #(
    parameter int unsigned WORDS      = 4,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    ksa_mw_add_sched_if.slave bus,
    output logic [31:0]       add_p_o,
    output logic [31:0]       add_g_o,
    input  logic [32:0]       add_c_i,
    output logic              busy_o
);
    localparam int unsigned     N     = 32 * WORDS;
    localparam int unsigned     CntW  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CntW-1:0] LastK = CntW'(WORDS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                     state_q, state_d;
    logic [CntW-1:0]            k_q, k_d;
    logic [WORDS-1:0][31:0]     a_q, a_d;
    logic [WORDS-1:0][31:0]     b_q, b_d;
    logic [WORDS-1:0][31:0]     sum_q, sum_d;
    logic                       carry_q, carry_d;
    logic                       cout_q, cout_d;
    logic                       id_q, id_d;
    logic                       rr_q, rr_d;    // requester preferred on a tie

    logic                       sel;
    logic                       req_fire;
    logic [31:0]                p_w, g_w, sum_w;
    logic [32:0]                q_w;
    logic                       carry_w;

    // Arbitration: tie goes to the round-robin pointer unless fixed priority.
    always_comb begin
        if (FIXED_PRIO || (bus.req_valid_i != 2'b11)) begin
            sel = ~bus.req_valid_i[0];
        end else begin
            sel = rr_q;
        end
    end

    // Grant is suppressed while reset is asserted so every output reads 0.
    assign req_fire        = (state_q == StIdle) && (|bus.req_valid_i) && rst_ni;
    assign bus.req_ready_o = req_fire ? (sel ? 2'b10 : 2'b01) : 2'b00;

    // Current-word propagate/generate, carry-in injection and word carry-out.
    always_comb begin
        logic acc;
        p_w = a_q[k_q] ^ b_q[k_q];
        g_w = a_q[k_q] & b_q[k_q];
        acc = 1'b1;
        for (int i = 0; i < 32; i++) begin
            q_w[i] = acc;
            acc    = acc & p_w[i];
        end
        q_w[32] = acc;
        sum_w   = p_w ^ (add_c_i[31:0] | (q_w[31:0] & {32{carry_q}}));
        carry_w = add_c_i[32] | (q_w[32] & carry_q);
    end

    assign add_p_o = (state_q == StRun) ? p_w : 32'h0;
    assign add_g_o = (state_q == StRun) ? g_w : 32'h0;

    // Next-state logic for the IDLE -> RUN -> DONE sequencer.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        id_d    = id_q;
        rr_d    = rr_q;
        unique case (state_q)
            StIdle: begin
                if (req_fire) begin
                    a_d     = sel ? bus.req_a_i[2*N-1:N] : bus.req_a_i[N-1:0];
                    b_d     = sel ? bus.req_b_i[2*N-1:N] : bus.req_b_i[N-1:0];
                    // The carry register doubles as the latched carry-in for word 0.
                    carry_d = bus.req_cin_i[sel];
                    id_d    = sel;
                    rr_d    = ~sel;
                    k_d     = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[k_q] = sum_w;
                carry_d    = carry_w;
                if (k_q == LastK) begin
                    cout_d  = carry_w;
                    k_d     = '0;
                    state_d = StDone;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            id_q    <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
        end
    end

    assign bus.rsp_valid_o = (state_q == StDone);
    assign bus.rsp_id_o    = id_q;
    assign bus.rsp_sum_o   = sum_q;
    assign bus.rsp_cout_o  = cout_q;
    assign busy_o          = (state_q != StIdle);

endmodule

// File: tb/tb_ksa_mw_add_sched.sv
// Bench for ksa_mw_add_sched: vector table, hand-written corner sequences and a
// randomized run against an arithmetic reference model.
module tb_ksa_mw_add_sched;
    localparam int unsigned WORDS = 4;
    localparam int unsigned N     = 32 * WORDS;
    localparam int unsigned NOPS  = 3000;
    localparam int unsigned MAXCYC = 60000;

    typedef logic [N:0] wide_t;

    typedef struct {
        logic         id;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic [N-1:0] sum;
        logic         cout;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ksa_mw_add_sched_if #(.N(N)) bus0 ();
    ksa_mw_add_sched_if #(.N(N)) bus1 ();

    logic [31:0] add_p0, add_g0, add_p1, add_g1;
    logic [32:0] add_c0, add_c1;
    logic        busy0, busy1;

    ksa_mw_add_sched #(.WORDS(WORDS), .FIXED_PRIO(1'b0)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus0),
        .add_p_o(add_p0), .add_g_o(add_g0), .add_c_i(add_c0), .busy_o(busy0)
    );

    ksa_mw_add_sched #(.WORDS(WORDS), .FIXED_PRIO(1'b1)) u_dut_fp (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus1),
        .add_p_o(add_p1), .add_g_o(add_g1), .add_c_i(add_c1), .busy_o(busy1)
    );

    // External combinational carry network: C[0]=0, C[i+1]=G[i]|P[i]&C[i].
    function automatic logic [32:0] carry_net(input logic [31:0] p, input logic [31:0] g);
        logic [32:0] c;
        c[0] = 1'b0;
        for (int i = 0; i < 32; i++) c[i+1] = g[i] | (p[i] & c[i]);
        return c;
    endfunction

    assign add_c0 = carry_net(add_p0, add_g0);
    assign add_c1 = carry_net(add_p1, add_g1);

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input wide_t act, input wide_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic wide_t golden(input logic [N-1:0] a, input logic [N-1:0] b,
                                     input logic cin);
        return {1'b0, a} + {1'b0, b} + wide_t'(cin);
    endfunction

    function automatic logic [N-1:0] rnd_opnd();
        logic [N-1:0] x;
        for (int i = 0; i < WORDS; i++) x[i*32 +: 32] = $urandom;
        case ($urandom_range(0, 5))
            0: x = '1;
            1: x = '0;
            2: x[31:0] = 32'hFFFF_FFFF;
            default: ;
        endcase
        return x;
    endfunction

    task automatic drive_req(input int r, input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic cin);
        bus0.req_a_i[r*N +: N] = a;
        bus0.req_b_i[r*N +: N] = b;
        bus0.req_cin_i[r]      = cin;
        bus0.req_valid_i[r]    = 1'b1;
    endtask

    // Waits for a grant on bus0, checks it, and returns just after the accept edge.
    task automatic wait_grant(input logic [1:0] exp, input bit drop);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus0.req_ready_o != 2'b00) begin
                seen = 1'b1;
                chk("grant", bus0.req_ready_o, exp);
            end
        end
        chk("grant_seen", seen, 1'b1);
        @(posedge clk);
        #1;
        if (drop) bus0.req_valid_i = bus0.req_valid_i & ~exp;
    endtask

    // Waits for the response (rsp_ready_i held high) and checks it and its latency.
    task automatic wait_rsp(input logic id, input wide_t exp, input bit chk_lat);
        bit seen;
        int lat;
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (bus0.rsp_valid_o) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        chk("rsp_seen", seen, 1'b1);
        if (seen) begin
            if (chk_lat) chk("rsp_latency", lat, WORDS + 1);
            chk("rsp_id", bus0.rsp_id_o, id);
            chk("rsp_sum", bus0.rsp_sum_o, exp[N-1:0]);
            chk("rsp_cout", bus0.rsp_cout_o, exp[N]);
            chk("rsp_no_grant", bus0.req_ready_o, 2'b00);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t          vecs[7];
    logic [N-1:0]  xa, xb, ya, yb;
    logic          xc, yc;
    wide_t         xg, yg;
    bit            seen;
    // Random-phase reference model state.
    logic          inflight, last_g, w, model_hs;
    int            age, granted, done, cyc;
    logic [1:0]    v, exp_rdy;
    wide_t         q_sum[$];
    logic          q_id[$];

    initial begin
        vecs[0] = '{id: 1'b0, a: '1, b: 128'd1, cin: 1'b0, sum: '0, cout: 1'b1};
        vecs[1] = '{id: 1'b0, a: 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, b: '0, cin: 1'b1,
                    sum: 128'h00000001_00000000_00000000_00000000, cout: 1'b0};
        vecs[2] = '{id: 1'b1, a: 128'd5, b: 128'd7, cin: 1'b0, sum: 128'd12, cout: 1'b0};
        vecs[3] = '{id: 1'b1, a: '1, b: '1, cin: 1'b1, sum: '1, cout: 1'b1};
        vecs[4] = '{id: 1'b0, a: 128'h80000000_00000000_00000000_00000000,
                    b: 128'h80000000_00000000_00000000_00000000, cin: 1'b0,
                    sum: '0, cout: 1'b1};
        vecs[5] = '{id: 1'b1, a: 128'hFFFFFFFF, b: '0, cin: 1'b1,
                    sum: 128'h1_00000000, cout: 1'b0};
        vecs[6] = '{id: 1'b0, a: 128'h0000FFFF_00000000_FFFFFFFF_12345678,
                    b: 128'h00000001_00000000_00000001_00000000, cin: 1'b0,
                    sum: 128'h00010000_00000001_00000000_12345678, cout: 1'b0};

        rst_n = 1'b0;
        bus0.req_valid_i = 2'b11;
        bus0.req_a_i = '1;
        bus0.req_b_i = '1;
        bus0.req_cin_i = 2'b11;
        bus0.rsp_ready_i = 1'b1;
        bus1.req_valid_i = 2'b00;
        bus1.req_a_i = '0;
        bus1.req_b_i = '0;
        bus1.req_cin_i = 2'b00;
        bus1.rsp_ready_i = 1'b1;

        // Reset state, with requests pending.
        repeat (3) @(negedge clk);
        chk("rst_req_ready", bus0.req_ready_o, 2'b00);
        chk("rst_rsp_valid", bus0.rsp_valid_o, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_add_p", add_p0, 32'h0);
        chk("rst_add_g", add_g0, 32'h0);
        chk("rst_rsp_sum", bus0.rsp_sum_o, '0);
        chk("rst_rsp_cout", bus0.rsp_cout_o, 1'b0);
        chk("rst_rsp_id", bus0.rsp_id_o, 1'b0);
        bus0.req_valid_i = 2'b00;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Vector table, one requester at a time.
        for (int i = 0; i < 7; i++) begin
            drive_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin);
            wait_grant(vecs[i].id ? 2'b10 : 2'b01, 1'b1);
            wait_rsp(vecs[i].id, {vecs[i].cout, vecs[i].sum}, 1'b1);
        end

        // Round robin with both requesters held valid.
        reset_pulse();
        xa = rnd_opnd(); xb = rnd_opnd(); xc = 1'b1;
        ya = rnd_opnd(); yb = rnd_opnd(); yc = 1'b0;
        xg = golden(xa, xb, xc);
        yg = golden(ya, yb, yc);
        drive_req(0, xa, xb, xc);
        drive_req(1, ya, yb, yc);
        for (int i = 0; i < 8; i++) begin
            wait_grant((i % 2) ? 2'b10 : 2'b01, 1'b0);
            wait_rsp(1'((i % 2)), (i % 2) ? yg : xg, 1'b1);
        end

        // Back-pressure in DONE: response held, nothing granted.
        bus0.rsp_ready_i = 1'b0;
        wait_grant(2'b01, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = bus0.rsp_valid_o;
        end
        chk("hold_seen", seen, 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", bus0.rsp_valid_o, 1'b1);
            chk("hold_sum", {bus0.rsp_cout_o, bus0.rsp_sum_o}, xg);
            chk("hold_id", bus0.rsp_id_o, 1'b0);
            chk("hold_req_ready", bus0.req_ready_o, 2'b00);
            chk("hold_busy", busy0, 1'b1);
            @(negedge clk);
        end
        chk("hs_cycle_no_grant", bus0.req_ready_o, 2'b00);
        bus0.rsp_ready_i = 1'b1;
        #1;
        chk("hs_cycle_no_grant2", bus0.req_ready_o, 2'b00);
        @(negedge clk);
        chk("after_hs_busy", busy0, 1'b0);
        chk("after_hs_valid", bus0.rsp_valid_o, 1'b0);
        chk("after_hs_grant", bus0.req_ready_o, 2'b10);
        @(posedge clk);
        #1;
        bus0.req_valid_i = 2'b00;
        wait_rsp(1'b1, yg, 1'b1);

        // Reset in the middle of RUN (word 2), then resume.
        xa = rnd_opnd(); xb = rnd_opnd(); xc = 1'b1;
        xa[95:64] = 32'h0F0F_1234;
        xb[95:64] = 32'h00FF_0000;
        ya = rnd_opnd(); yb = rnd_opnd(); yc = 1'b1;
        xg = golden(xa, xb, xc);
        yg = golden(ya, yb, yc);
        drive_req(1, xa, xb, xc);
        wait_grant(2'b10, 1'b0);
        repeat (3) @(negedge clk);
        chk("mid_add_p_word2", add_p0, xa[95:64] ^ xb[95:64]);
        chk("mid_busy", busy0, 1'b1);
        #1;
        rst_n = 1'b0;
        drive_req(0, ya, yb, yc);
        #1;
        chk("mid_rst_add_p", add_p0, 32'h0);
        chk("mid_rst_add_g", add_g0, 32'h0);
        chk("mid_rst_busy", busy0, 1'b0);
        chk("mid_rst_rsp_valid", bus0.rsp_valid_o, 1'b0);
        chk("mid_rst_req_ready", bus0.req_ready_o, 2'b00);
        chk("mid_rst_rsp_sum", bus0.rsp_sum_o, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_grant(2'b01, 1'b1);
        wait_rsp(1'b0, yg, 1'b1);
        wait_grant(2'b10, 1'b1);
        wait_rsp(1'b1, xg, 1'b1);

        // Fixed priority instance: requester 0 always wins.
        xa = rnd_opnd(); xb = rnd_opnd();
        xg = golden(xa, xb, 1'b0);
        bus1.req_a_i = {rnd_opnd(), xa};
        bus1.req_b_i = {rnd_opnd(), xb};
        bus1.req_cin_i = 2'b10;
        bus1.req_valid_i = 2'b11;
        for (int i = 0; i < 8; i++) begin
            seen = 1'b0;
            for (int j = 0; j < 40 && !seen; j++) begin
                @(negedge clk);
                if (bus1.req_ready_o != 2'b00) begin
                    seen = 1'b1;
                    chk("fp_grant", bus1.req_ready_o, 2'b01);
                end
            end
            chk("fp_grant_seen", seen, 1'b1);
            @(posedge clk);
            #1;
            seen = 1'b0;
            for (int j = 0; j < 40 && !seen; j++) begin
                @(negedge clk);
                if (bus1.rsp_valid_o) begin
                    seen = 1'b1;
                    chk("fp_id", bus1.rsp_id_o, 1'b0);
                    chk("fp_sum", {bus1.rsp_cout_o, bus1.rsp_sum_o}, xg);
                end
            end
            chk("fp_rsp_seen", seen, 1'b1);
            @(posedge clk);
            #1;
        end
        bus1.req_valid_i = 2'b00;

        // Randomized traffic against the reference model.
        bus0.req_valid_i = 2'b00;
        reset_pulse();
        inflight = 1'b0;
        last_g   = 1'b1;
        age      = 0;
        granted  = 0;
        done     = 0;
        cyc      = 0;
        w        = 1'b0;
        while ((granted < NOPS || done < granted) && cyc < MAXCYC) begin
            @(negedge clk);
            v = bus0.req_valid_i;
            exp_rdy = 2'b00;
            if (!inflight && v != 2'b00) begin
                w = (v == 2'b11) ? ~last_g : v[1];
                exp_rdy = w ? 2'b10 : 2'b01;
            end
            chk("rnd_req_ready", bus0.req_ready_o, exp_rdy);
            chk("rnd_busy", busy0, inflight);
            chk("rnd_rsp_valid", bus0.rsp_valid_o, inflight && (age >= WORDS));
            model_hs = inflight && (age >= WORDS) && bus0.rsp_ready_i;
            if (model_hs) begin
                chk("rnd_queue_nonempty", q_sum.size() > 0, 1'b1);
                if (q_sum.size() > 0) begin
                    chk("rnd_rsp_id", bus0.rsp_id_o, q_id[0]);
                    chk("rnd_rsp_sum", {bus0.rsp_cout_o, bus0.rsp_sum_o}, q_sum[0]);
                    void'(q_sum.pop_front());
                    void'(q_id.pop_front());
                end
            end
            if (exp_rdy != 2'b00) begin
                q_sum.push_back(golden(bus0.req_a_i[w*N +: N], bus0.req_b_i[w*N +: N],
                                       bus0.req_cin_i[w]));
                q_id.push_back(w);
            end
            @(posedge clk);
            cyc++;
            if (model_hs) begin
                inflight = 1'b0;
                done++;
            end
            if (exp_rdy != 2'b00) begin
                inflight = 1'b1;
                age      = 0;
                last_g   = w;
                granted++;
            end else if (inflight) begin
                age++;
            end
            #1;
            if (exp_rdy != 2'b00) bus0.req_valid_i[w] = 1'b0;
            for (int r = 0; r < 2; r++) begin
                if (!bus0.req_valid_i[r]) begin
                    if (granted < NOPS && $urandom_range(0, 1) == 1) begin
                        xa = rnd_opnd();
                        case ($urandom_range(0, 3))
                            0: xb = ~xa;
                            1: xb = 128'd1;
                            default: xb = rnd_opnd();
                        endcase
                        drive_req(r, xa, xb, 1'($urandom_range(0, 1)));
                    end
                end else if ($urandom_range(0, 31) == 0) begin
                    bus0.req_valid_i[r] = 1'b0;
                end
            end
            bus0.rsp_ready_i = ($urandom_range(0, 3) != 0);
        end
        chk("rnd_within_budget", cyc < MAXCYC, 1'b1);
        chk("rnd_all_done", done, granted);
        chk("rnd_queue_drained", q_sum.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
